// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan multiplexer.
// Contents: segment pattern constants in {g,f,e,d,c,b,a} order, active-low
// (0 = segment lit), the snapshotted display-mode bundle, and the nibble
// decode function used by seg7_hex_decode.
package seg7_pkg;

    localparam int unsigned SEG_W = 7;
    localparam int unsigned NIB_W = 4;
    localparam int unsigned PWM_W = 4;

    localparam logic [SEG_W-1:0] SEG_0   = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG_1   = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_2   = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_3   = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_4   = 7'b0011001;
    localparam logic [SEG_W-1:0] SEG_5   = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_6   = 7'b0000010;
    localparam logic [SEG_W-1:0] SEG_7   = 7'b1111000;
    localparam logic [SEG_W-1:0] SEG_8   = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9   = 7'b0010000;
    localparam logic [SEG_W-1:0] SEG_A   = 7'b0001000;
    localparam logic [SEG_W-1:0] SEG_B   = 7'b0000011;
    localparam logic [SEG_W-1:0] SEG_C   = 7'b1000110;
    localparam logic [SEG_W-1:0] SEG_D   = 7'b0100001;
    localparam logic [SEG_W-1:0] SEG_E   = 7'b0000110;
    localparam logic [SEG_W-1:0] SEG_F   = 7'b0001110;
    localparam logic [SEG_W-1:0] SEG_OFF = 7'b1111111;

    // Display-mode bits captured together with the digit snapshot.
    typedef struct packed {
        logic hex_mode;
        logic lz_blank;
    } seg7_mode_t;

    // Nibble to active-low pattern; in BCD mode values above 9 show nothing.
    function automatic logic [SEG_W-1:0] hex_to_seg(input logic [NIB_W-1:0] nibble,
                                                    input logic             hex_mode);
        logic [SEG_W-1:0] pat;
        pat = SEG_OFF;
        case (nibble)
            4'h0: pat = SEG_0;
            4'h1: pat = SEG_1;
            4'h2: pat = SEG_2;
            4'h3: pat = SEG_3;
            4'h4: pat = SEG_4;
            4'h5: pat = SEG_5;
            4'h6: pat = SEG_6;
            4'h7: pat = SEG_7;
            4'h8: pat = SEG_8;
            4'h9: pat = SEG_9;
            4'hA: pat = hex_mode ? SEG_A : SEG_OFF;
            4'hB: pat = hex_mode ? SEG_B : SEG_OFF;
            4'hC: pat = hex_mode ? SEG_C : SEG_OFF;
            4'hD: pat = hex_mode ? SEG_D : SEG_OFF;
            4'hE: pat = hex_mode ? SEG_E : SEG_OFF;
            4'hF: pat = hex_mode ? SEG_F : SEG_OFF;
            default: pat = SEG_OFF;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/seg7_scan_mux_if.sv
// Bundle between the datapath (master) and the scan multiplexer (slave).
// master drives: digits_in, dp_in, hex_mode, lz_blank, brightness
// slave drives : sseg {g..a}, dp, digit (anode enables), frame_tick
interface seg7_scan_mux_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] digits_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    hex_mode;
    logic                    lz_blank;
    logic [3:0]              brightness;
    logic [6:0]              sseg;
    logic                    dp;
    logic [NUM_DIGITS-1:0]   digit;
    logic                    frame_tick;

    modport master (
        output digits_in, dp_in, hex_mode, lz_blank, brightness,
        input  sseg, dp, digit, frame_tick
    );

    modport slave (
        input  digits_in, dp_in, hex_mode, lz_blank, brightness,
        output sseg, dp, digit, frame_tick
    );
endinterface

// File: rtl/seg7_hex_decode.sv
// Combinational nibble decoder producing an active-low segment pattern.
// Ports: i_nibble (value), i_hex_mode (1 = A-F shown), o_seg_c {g..a}.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [NIB_W-1:0] i_nibble,
    input  logic             i_hex_mode,
    output logic [SEG_W-1:0] o_seg_c
);

    always_comb begin
        o_seg_c = hex_to_seg(i_nibble, i_hex_mode);
    end

endmodule

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed 7-segment driver with per-frame input snapshot,
// leading-zero blanking, inter-digit dead time and 16-level PWM dimming.
// Ports: clk_100MHz, reset (async, active-high), bus (slave modport):
//   inputs  digits_in/dp_in/hex_mode/lz_blank (snapshotted), brightness (live)
//   outputs sseg/dp/digit (registered, latency 1), frame_tick (1-cycle pulse)
module seg7_scan_mux
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned SCAN_DIV       = 125000,
    parameter int unsigned BLANK_CYCLES   = 1000,
    parameter bit          ACTIVE_LOW_SEG = 1'b1,
    parameter bit          ACTIVE_LOW_AN  = 1'b1
)(
    input  logic           clk_100MHz,
    input  logic           reset,
    seg7_scan_mux_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(SCAN_DIV);
    localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
    localparam int unsigned DIG_W = NIB_W * NUM_DIGITS;

    localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]      BLANK_CNT = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [SEG_W-1:0]      SEG_IDLE  = ACTIVE_LOW_SEG ? SEG_OFF : ~SEG_OFF;
    localparam logic                  DP_IDLE   = ACTIVE_LOW_SEG;
    localparam logic [NUM_DIGITS-1:0] AN_IDLE   = {NUM_DIGITS{ACTIVE_LOW_AN}};

    logic [CNT_W-1:0]      r_slot_cnt;
    logic [IDX_W-1:0]      r_slot_idx;
    logic [PWM_W-1:0]      r_pwm_cnt;
    logic [DIG_W-1:0]      r_digits;
    logic [NUM_DIGITS-1:0] r_dp_req;
    seg7_mode_t            r_mode;
    logic                  r_frame_tick;
    logic [SEG_W-1:0]      r_sseg;
    logic                  r_dp;
    logic [NUM_DIGITS-1:0] r_digit;

    logic                  w_slot_end;
    logic                  w_frame_end;
    logic [NUM_DIGITS-1:0] w_lz_mask;
    logic [NIB_W-1:0]      w_nibble;
    logic                  w_dp_cur;
    logic                  w_lz_cur;
    logic [NUM_DIGITS-1:0] w_onehot;
    logic [SEG_W-1:0]      w_pattern;
    logic [SEG_W-1:0]      w_seg_low;
    logic                  w_lit;

    assign w_slot_end  = (r_slot_cnt == CNT_LAST);
    assign w_frame_end = w_slot_end && (r_slot_idx == IDX_LAST);

    // Slot timing: dwell counter, digit index and per-slot PWM phase.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            r_slot_cnt <= '0;
            r_slot_idx <= '0;
            r_pwm_cnt  <= '0;
        end else if (w_slot_end) begin
            r_slot_cnt <= '0;
            r_pwm_cnt  <= '0;
            r_slot_idx <= (r_slot_idx == IDX_LAST) ? '0 : r_slot_idx + IDX_W'(1);
        end else begin
            r_slot_cnt <= r_slot_cnt + CNT_W'(1);
            r_pwm_cnt  <= r_pwm_cnt + PWM_W'(1);
        end
    end

    // Frame-coherent snapshot so a frame never mixes old and new values.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            r_digits     <= '0;
            r_dp_req     <= '0;
            r_mode       <= '0;
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= w_frame_end;
            if (w_frame_end) begin
                r_digits        <= bus.digits_in;
                r_dp_req        <= bus.dp_in;
                r_mode.hex_mode <= bus.hex_mode;
                r_mode.lz_blank <= bus.lz_blank;
            end
        end
    end

    // Digit i is a leading zero when it and every more-significant nibble are 0.
    always_comb begin
        logic v_all_zero;
        v_all_zero = 1'b1;
        w_lz_mask  = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            v_all_zero   = v_all_zero && (r_digits[NIB_W*i +: NIB_W] == 4'h0);
            w_lz_mask[i] = r_mode.lz_blank && (i != 0) && v_all_zero;
        end
    end

    // Select the fields of the digit currently being scanned.
    always_comb begin
        w_nibble = '0;
        w_dp_cur = 1'b0;
        w_lz_cur = 1'b0;
        w_onehot = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_slot_idx == IDX_W'(i)) begin
                w_nibble    = r_digits[NIB_W*i +: NIB_W];
                w_dp_cur    = r_dp_req[i];
                w_lz_cur    = w_lz_mask[i];
                w_onehot[i] = 1'b1;
            end
        end
    end

    seg7_hex_decode u_decode (
        .i_nibble   (w_nibble),
        .i_hex_mode (r_mode.hex_mode),
        .o_seg_c    (w_pattern)
    );

    // A blanked leading zero with its dp requested stays lit showing only dp.
    assign w_seg_low = w_lz_cur ? SEG_OFF : w_pattern;
    assign w_lit     = (r_slot_cnt >= BLANK_CNT) &&
                       (r_pwm_cnt <= bus.brightness) &&
                       (!w_lz_cur || w_dp_cur);

    // Pin registers with board polarity applied.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            r_sseg  <= SEG_IDLE;
            r_dp    <= DP_IDLE;
            r_digit <= AN_IDLE;
        end else if (w_lit) begin
            r_sseg  <= ACTIVE_LOW_SEG ? w_seg_low : ~w_seg_low;
            r_dp    <= ACTIVE_LOW_SEG ? ~w_dp_cur : w_dp_cur;
            r_digit <= ACTIVE_LOW_AN ? ~w_onehot : w_onehot;
        end else begin
            r_sseg  <= SEG_IDLE;
            r_dp    <= DP_IDLE;
            r_digit <= AN_IDLE;
        end
    end

    assign bus.sseg       = r_sseg;
    assign bus.dp         = r_dp;
    assign bus.digit      = r_digit;
    assign bus.frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Directed bench for seg7_scan_mux: a 4-digit active-low instance with
// SCAN_DIV=32/BLANK_CYCLES=4 and an 8-digit active-high instance.
module tb_seg7_scan_mux;

    localparam int unsigned SLOT  = 32;
    localparam int unsigned FRAME = 4 * SLOT;

    logic clk_100MHz;
    logic reset;

    seg7_scan_mux_if #(.NUM_DIGITS(4)) bus4 ();
    seg7_scan_mux_if #(.NUM_DIGITS(8)) bus8 ();

    seg7_scan_mux #(
        .NUM_DIGITS(4), .SCAN_DIV(32), .BLANK_CYCLES(4),
        .ACTIVE_LOW_SEG(1'b1), .ACTIVE_LOW_AN(1'b1)
    ) u_dut (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .bus        (bus4)
    );

    seg7_scan_mux #(
        .NUM_DIGITS(8), .SCAN_DIV(32), .BLANK_CYCLES(4),
        .ACTIVE_LOW_SEG(1'b0), .ACTIVE_LOW_AN(1'b0)
    ) u_dut8 (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .bus        (bus8)
    );

    initial clk_100MHz = 1'b0;
    always #5 clk_100MHz = ~clk_100MHz;

    int n_checks = 0;
    int n_fail   = 0;
    int n_multi  = 0;

    logic [6:0] s_seg [FRAME];
    logic       s_dp  [FRAME];
    logic [3:0] s_dig [FRAME];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // More than one anode active at once on either instance.
    always @(negedge clk_100MHz) begin
        if (!reset) begin
            if ($countones(~bus4.digit) > 1) n_multi++;
            if ($countones(bus8.digit) > 1)  n_multi++;
        end
    end

    task automatic wait_tick(input string tag);
        int n;
        n = 0;
        while (bus4.frame_tick !== 1'b1 && n < 400) begin
            @(negedge clk_100MHz);
            n++;
        end
        check_eq({tag, "_tick"}, 32'(bus4.frame_tick), 32'd1);
    endtask

    // Record one frame; sample k holds the outputs for counter state k.
    task automatic collect(input int chg_k, input logic [15:0] chg_val);
        for (int k = 0; k < FRAME; k++) begin
            @(negedge clk_100MHz);
            s_seg[k] = bus4.sseg;
            s_dp[k]  = bus4.dp;
            s_dig[k] = bus4.digit;
            if (k == chg_k) bus4.digits_in = chg_val;
        end
    endtask

    task automatic next_frame(input string tag, input int chg_k, input logic [15:0] chg_val);
        wait_tick(tag);
        collect(chg_k, chg_val);
    endtask

    // segs = {slot3,slot2,slot1,slot0} active-low patterns; on/dpv per slot.
    task automatic check_frame(input string tag, input logic [27:0] segs,
                               input logic [3:0] on, input logic [3:0] dpv, input int cnt_on);
        for (int s = 0; s < 4; s++) begin
            int         cnt;
            logic [3:0] oh;
            logic [6:0] eseg;
            int         b;
            b    = s * SLOT;
            oh   = ~(4'b0001 << s);
            eseg = segs[7*s +: 7];
            cnt  = 0;
            for (int c = 0; c < SLOT; c++) if (s_dig[b + c] == oh) cnt++;
            check_eq($sformatf("%s_s%0d_cnt", tag, s), 32'(cnt), on[s] ? 32'(cnt_on) : 32'd0);
            check_eq($sformatf("%s_s%0d_dead", tag, s), 32'(s_dig[b + 2]), 32'hF);
            check_eq($sformatf("%s_s%0d_an", tag, s), 32'(s_dig[b + 17]), on[s] ? 32'(oh) : 32'hF);
            check_eq($sformatf("%s_s%0d_seg", tag, s), 32'(s_seg[b + 17]), on[s] ? 32'(eseg) : 32'h7F);
            check_eq($sformatf("%s_s%0d_dp", tag, s), 32'(s_dp[b + 17]), on[s] ? 32'(dpv[s]) : 32'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset           = 1'b1;
        bus4.digits_in  = 16'h0000;
        bus4.dp_in      = 4'b0000;
        bus4.hex_mode   = 1'b0;
        bus4.lz_blank   = 1'b0;
        bus4.brightness = 4'd15;
        bus8.digits_in  = 32'h7654_3210;
        bus8.dp_in      = 8'b0010_0000;
        bus8.hex_mode   = 1'b0;
        bus8.lz_blank   = 1'b0;
        bus8.brightness = 4'd15;

        repeat (3) @(negedge clk_100MHz);
        check_eq("rst_digit", 32'(bus4.digit), 32'hF);
        check_eq("rst_sseg", 32'(bus4.sseg), 32'h7F);
        check_eq("rst_dp", 32'(bus4.dp), 32'd1);
        check_eq("rst_tick", 32'(bus4.frame_tick), 32'd0);
        check_eq("rst_digit8", 32'(bus8.digit), 32'h00);

        // Before any snapshot the display shows zeros.
        reset = 1'b0;
        repeat (11) @(negedge clk_100MHz);
        check_eq("presnap_an", 32'(bus4.digit), 32'hE);
        check_eq("presnap_seg", 32'(bus4.sseg), 32'h40);

        bus4.digits_in = 16'h1234;
        next_frame("f1234", -1, 16'h0);
        check_frame("d1234", {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}, 4'hF, 4'hF, 28);

        // Change mid-frame: current frame keeps the old snapshot.
        next_frame("fstale", 40, 16'h5678);
        check_frame("stale", {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}, 4'hF, 4'hF, 28);
        next_frame("f5678", -1, 16'h0);
        check_frame("d5678", {7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000}, 4'hF, 4'hF, 28);

        bus4.digits_in = 16'h00A0;
        next_frame("fbcd_a", -1, 16'h0);
        next_frame("fbcd_b", -1, 16'h0);
        check_frame("bcdA", {7'b1000000, 7'b1000000, 7'b1111111, 7'b1000000}, 4'hF, 4'hF, 28);

        bus4.hex_mode = 1'b1;
        next_frame("fhex_a", -1, 16'h0);
        next_frame("fhex_b", -1, 16'h0);
        check_frame("hexA", {7'b1000000, 7'b1000000, 7'b0001000, 7'b1000000}, 4'hF, 4'hF, 28);

        bus4.hex_mode  = 1'b0;
        bus4.lz_blank  = 1'b1;
        bus4.digits_in = 16'h0005;
        next_frame("flz_a", -1, 16'h0);
        next_frame("flz_b", -1, 16'h0);
        check_frame("lz", {7'h7F, 7'h7F, 7'h7F, 7'b0010010}, 4'b0001, 4'hF, 28);

        bus4.dp_in = 4'b0100;
        next_frame("flzdp_a", -1, 16'h0);
        next_frame("flzdp_b", -1, 16'h0);
        check_frame("lzdp", {7'h7F, 7'h7F, 7'h7F, 7'b0010010}, 4'b0101, 4'b1011, 28);

        bus4.dp_in      = 4'b0000;
        bus4.lz_blank   = 1'b0;
        bus4.digits_in  = 16'h1234;
        bus4.brightness = 4'd3;
        next_frame("fpwm_a", -1, 16'h0);
        next_frame("fpwm_b", -1, 16'h0);
        check_frame("pwm3", {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}, 4'hF, 4'hF, 4);

        // Reset in the middle of slot 2.
        bus4.brightness = 4'd15;
        wait_tick("fmid");
        repeat (74) @(negedge clk_100MHz);
        check_eq("mid_pre_an", 32'(bus4.digit), 32'hB);
        #1 reset = 1'b1;
        #1;
        check_eq("mid_rst_an", 32'(bus4.digit), 32'hF);
        check_eq("mid_rst_seg", 32'(bus4.sseg), 32'h7F);
        check_eq("mid_rst_an8", 32'(bus8.digit), 32'h00);
        check_eq("mid_rst_seg8", 32'(bus8.sseg), 32'h00);
        @(negedge clk_100MHz);
        reset = 1'b0;
        n = 0;
        while (bus4.frame_tick !== 1'b1 && n < 400) begin
            @(negedge clk_100MHz);
            n++;
            if (n == 11) begin
                check_eq("restart_an", 32'(bus4.digit), 32'hE);
                check_eq("restart_seg", 32'(bus4.sseg), 32'h40);
            end
        end
        check_eq("restart_tick_at", 32'(n), 32'(FRAME));

        // Active-high 8-digit instance: slot 5 shows 5 with dp.
        n = 0;
        while (bus8.frame_tick !== 1'b1 && n < 600) begin
            @(negedge clk_100MHz);
            n++;
        end
        check_eq("d8_tick", 32'(bus8.frame_tick), 32'd1);
        repeat (5 * SLOT + 18) @(negedge clk_100MHz);
        check_eq("d8_an", 32'(bus8.digit), 32'h20);
        check_eq("d8_seg", 32'(bus8.sseg), 32'h6D);
        check_eq("d8_dp", 32'(bus8.dp), 32'd1);

        check_eq("onehot", 32'(n_multi), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg7_scan_mux.md
Name: seg7_scan_mux

Overview:
Parametrised time-multiplexed driver for common-anode/cathode 7-segment arrays of NUM_DIGITS digits, the successor of the fixed 4-digit BCD scanner. It adds a frame-coherent input snapshot, per-digit decimal points, hex/BCD modes, leading-zero blanking, inter-digit dead time (anti-ghosting) and 16-level PWM brightness. It sits between counter/datapath logic and the board's seg/anode pins.

Parameters:
NUM_DIGITS, 4, digits scanned; legal 2..8
SCAN_DIV, 125000, clk cycles per digit slot; must exceed BLANK_CYCLES+16
BLANK_CYCLES, 1000, dead-time cycles at start of each slot (all anodes off)
ACTIVE_LOW_SEG, 1, 1 = segment/dp outputs active-low
ACTIVE_LOW_AN, 1, 1 = digit (anode) outputs active-low

Ports:
clk_100MHz  in  1  system clock
reset  in  1  asynchronous, active-high reset
digits_in  in  4*NUM_DIGITS  nibble i = digit i; digit 0 = rightmost (least significant)
dp_in  in  NUM_DIGITS  decimal point request per digit
hex_mode  in  1  1 = show 0-F; 0 = BCD, values 10-15 shown blank
lz_blank  in  1  1 = blank leading zeros
brightness  in  4  duty level; lit fraction = (brightness+1)/16 of on-window
sseg  out  7  {g,f,e,d,c,b,a}
dp  out  1  decimal point segment
digit  out  NUM_DIGITS  anode enables, one-hot (polarity per ACTIVE_LOW_AN)
frame_tick  out  1  one-cycle pulse when a new snapshot is taken

Behaviour:
- Interface: one clock clk_100MHz; reset is asynchronous, active-high; all state cleared on assertion, release synchronous to clk_100MHz.
- Reset values: digit all inactive, sseg all segments off, dp off, frame_tick 0, slot counter 0, slot index 0, pwm counter 0, snapshot registers 0.
- Slot counter: 0..SCAN_DIV-1, width $clog2(SCAN_DIV); on SCAN_DIV-1 wraps to 0 and slot index increments; index wraps NUM_DIGITS-1 -> 0.
- Scan order: index 0 (rightmost) first, ascending.
- Snapshot: digits_in, dp_in, hex_mode, lz_blank captured in the cycle counter=SCAN_DIV-1 and index=NUM_DIGITS-1; frame_tick asserted the following cycle for exactly one cycle. Until the first snapshot, display shows snapshot zeros. brightness is not snapshotted (sampled live).
- PWM: 4-bit counter cleared at each slot start, free-running (wraps 15->0) thereafter.
- Lit condition for current index s: counter >= BLANK_CYCLES AND pwm_cnt <= brightness AND digit s not blanked.
- Outputs registered: sseg/dp/digit reflect the counter state of the previous cycle (latency 1). When not lit: digit all inactive, sseg/dp off. At most one digit active in any cycle.
- Decode: 0-9 standard patterns (active-low 0 = 1000000); hex_mode=1: A,b,C,d,E,F; hex_mode=0 and value>9 -> all segments off (dp still honoured).
- Leading-zero blank (lz_blank=1): digit i (i>0) blanked iff nibbles i..NUM_DIGITS-1 are all zero; digit 0 never blanked. A blanked digit with dp requested stays lit showing only dp.
- Reset mid-slot: outputs go inactive immediately (async), scan restarts at index 0, count 0.
- brightness change mid-slot takes effect next cycle; no glitch beyond the one-cycle latency.

Decomposition:
- Package seg7_pkg: 7-bit pattern constants SEG_0..SEG_F, SEG_OFF, function hex_to_seg(nibble, hex_mode) returning active-low pattern.
- Sub-module seg7_hex_decode (combinational nibble/hex_mode -> pattern, polarity applied at top).
- Top holds counters, snapshot, blanking logic, output registers.

Test Plan:
- Sim params NUM_DIGITS=4, SCAN_DIV=32, BLANK_CYCLES=4; reset, digits_in=16'h1234, brightness=15 -> after first frame_tick, slot 0 shows sseg=0011001 (4) with digit=1110 for cycles 4..31, 1111 for cycles 0..3; slots 1-3 show 3,2,1.
- Change digits_in mid-frame from 16'h1234 to 16'h5678 -> current frame still shows 1234; next frame after frame_tick shows 5678.
- digits_in=16'h00A0, hex_mode=0 -> digit1 blank; hex_mode=1 -> digit1 shows 0001000 (A); lz_blank=1 with 16'h0005 -> only digit 0 lights; dp_in=4'b0100 keeps digit2 lit with sseg off, dp=0.
- brightness=3 -> digit active exactly 4 of every 16 on-window cycles (pwm_cnt 0..3); brightness=15 -> active all 28 on-window cycles.
- Assert reset mid-slot 2 -> same cycle digit=1111, sseg=1111111; after release scan restarts at slot 0, frame_tick absent until frame completes.
- Params ACTIVE_LOW_SEG=0, ACTIVE_LOW_AN=0, NUM_DIGITS=8 -> inverted polarities, 8 slots per frame, one-hot digit never multi-hot (assertion over full run).
